// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, scoreboard slot and
// the fixed control-transfer latency (cycles a ctrl instr spends in EX and MEM).
package hazard_ctrl_pkg;

    localparam int HZ_RFADDR   = 5;
    localparam int HZ_CTRL_LAT = 2;

    typedef enum logic {HZ_RUN, HZ_CTRL_WAIT} hz_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 wr_en;
        logic [HZ_RFADDR-1:0] rd;
    } hz_slot_t;

    function automatic logic slot_hit(hz_slot_t s, logic [HZ_RFADDR-1:0] r);
        return s.valid & s.wr_en & (s.rd == r);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side handshake between the datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
    parameter int RFADDR = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [RFADDR-1:0] id_rs1;
    logic [RFADDR-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [RFADDR-1:0] id_rd;
    logic              id_rf_wr_en;
    logic              id_ctrl;
    logic              wb_redirect;

    logic              pc_en;
    logic              ifid_en;
    logic              ifid_kill;
    logic              idex_bubble;
    logic              busy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_rf_wr_en, id_ctrl, wb_redirect,
        input  pc_en, ifid_en, ifid_kill, idex_bubble, busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_rf_wr_en, id_ctrl, wb_redirect,
        output pc_en, ifid_en, ifid_kill, idex_bubble, busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hz_scoreboard.sv
// Three-slot shadow of the EX/MEM/WB destination registers; shifts every cycle and
// reports whether either decode source matches a pending write.
module hz_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  hz_slot_t             push,
    input  logic [HZ_RFADDR-1:0] rs1,
    input  logic [HZ_RFADDR-1:0] rs2,
    output logic                 hit1,
    output logic                 hit2
);
    // slots[0]=EX, slots[1]=MEM, slots[2]=WB
    hz_slot_t [2:0] slots;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) slots <= '0;
        else          slots <= {slots[1:0], push};
    end

    // WB is included: the regfile write lands at the end of WB, so no same-cycle bypass.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hit1 = hit1 | slot_hit(slots[i], rs1);
            hit2 = hit2 | slot_hit(slots[i], rs2);
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the IF->ID->EX->MEM->WB pipeline: RAW interlock against
// the EX/MEM/WB scoreboard and a fetch hold while a control transfer travels to WB.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RFADDR = 5,
    parameter int CNT_W  = 32
) (
    input logic          clk,
    input logic          reset_n,
    hazard_ctrl_if.slave hz
);
    if (RFADDR != HZ_RFADDR) begin : g_bad_rfaddr
        $error("hazard_ctrl: RFADDR must match HZ_RFADDR");
    end

    hz_state_t        state;
    logic [1:0]       cnt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic     hit1, hit2;
    logic     hazard, issue_ctrl, wb_slot, redirect;
    hz_slot_t push;

    assign push = '{valid: hz.id_valid & ~hz.idex_bubble,
                    wr_en: hz.id_rf_wr_en,
                    rd:    hz.id_rd};

    hz_scoreboard u_sb (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .rs1     (hz.id_rs1),
        .rs2     (hz.id_rs2),
        .hit1    (hit1),
        .hit2    (hit2)
    );

    // x0 is hardwired, so a pending write to it never blocks a reader.
    assign hazard = hz.id_valid &
                    ((hz.id_use_rs1 & (hz.id_rs1 != '0) & hit1) |
                     (hz.id_use_rs2 & (hz.id_rs2 != '0) & hit2));

    assign issue_ctrl = (state == HZ_RUN) & hz.id_valid & hz.id_ctrl & ~hazard;
    assign wb_slot    = (state == HZ_CTRL_WAIT) & (cnt == 2'd0);
    assign redirect   = wb_slot & hz.wb_redirect;

    always_comb begin
        hz.pc_en       = 1'b1;
        hz.ifid_en     = 1'b1;
        hz.ifid_kill   = 1'b0;
        hz.idex_bubble = 1'b0;
        if (issue_ctrl || (state == HZ_CTRL_WAIT && cnt != 2'd0)) begin
            hz.pc_en     = 1'b0;
            hz.ifid_kill = 1'b1;
        end
        if (redirect) hz.ifid_kill = 1'b1;
        if (hazard) begin
            hz.pc_en       = 1'b0;
            hz.ifid_en     = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end

    assign hz.busy      = hazard | (state == HZ_CTRL_WAIT) | issue_ctrl;
    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= HZ_RUN;
            cnt   <= 2'd0;
        end else begin
            case (state)
                HZ_RUN: if (issue_ctrl) begin
                    state <= HZ_CTRL_WAIT;
                    cnt   <= 2'(HZ_CTRL_LAT);
                end
                HZ_CTRL_WAIT: begin
                    if (cnt != 2'd0) cnt   <= cnt - 2'd1;
                    else             state <= HZ_RUN;
                end
                default: state <= HZ_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (hazard   && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (redirect && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end
endmodule
